// File: rtl/dxm_demux_buf.sv
// Registered 1-to-2 demultiplexer with a small FIFO on each output lane.
// Optional DXM_DEMUX_ALT_EN: lane chosen by an internal alternating toggle instead of control.
module dxm_demux_buf #(
  parameter int unsigned mux_width  = 1,
  parameter int unsigned lane_depth = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [mux_width-1:0] in_data,
  input  logic                 control,
  output logic                 out_low_valid,
  input  logic                 out_low_ready,
  output logic [mux_width-1:0] out_low,
  output logic                 out_high_valid,
  input  logic                 out_high_ready,
  output logic [mux_width-1:0] out_high,
  output logic                 busy
);

  localparam int unsigned PtrW = $clog2(lane_depth);
  localparam int unsigned CntW = PtrW + 1;

  // Index 0 is the low lane, index 1 the high lane.
  logic [mux_width-1:0] mem_q    [2][lane_depth];
  logic [PtrW-1:0]      wr_ptr_q [2];
  logic [PtrW-1:0]      rd_ptr_q [2];
  logic [CntW-1:0]      count_q  [2];

  logic       sel;
  logic [1:0] lane_valid;
  logic [1:0] lane_ready;
  logic [1:0] push;
  logic [1:0] pop;

`ifdef DXM_DEMUX_ALT_EN
  logic toggle_q;
  logic unused_control;

  assign unused_control = control;
  assign sel            = toggle_q;

  // Advances only on accept, so a blocked word keeps its lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      toggle_q <= ~toggle_q;
    end
  end
`else
  assign sel = control;
`endif

  assign lane_ready = {out_high_ready, out_low_ready};

  always_comb begin
    lane_valid[0] = (count_q[0] != '0);
    lane_valid[1] = (count_q[1] != '0);
    // Full lane blocks input even when it is popping this cycle.
    in_ready      = !reset && (count_q[sel] < CntW'(lane_depth));
    push          = 2'b00;
    if (in_valid && in_ready) begin
      push[sel] = 1'b1;
    end
    pop = lane_valid & lane_ready;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end else begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= in_data;
          wr_ptr_q[i]           <= wr_ptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + CntW'(1);
          2'b01:   count_q[i] <= count_q[i] - CntW'(1);
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

  // Empty lanes drive zeros rather than stale storage.
  always_comb begin
    out_low_valid  = lane_valid[0];
    out_high_valid = lane_valid[1];
    out_low        = lane_valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    out_high       = lane_valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    busy           = lane_valid[0] | lane_valid[1];
  end

endmodule

// File: tb/tb_dxm_demux_buf.sv
// Directed bench for dxm_demux_buf (mux_width=8, lane_depth=2) with per-lane scoreboard queues.
module tb_dxm_demux_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       control;
  logic       out_low_valid;
  logic       out_low_ready;
  logic [7:0] out_low;
  logic       out_high_valid;
  logic       out_high_ready;
  logic [7:0] out_high;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q_low[$];
  logic [7:0] q_high[$];
  logic       tog = 1'b0;

  dxm_demux_buf #(
    .mux_width (8),
    .lane_depth(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .control       (control),
    .out_low_valid (out_low_valid),
    .out_low_ready (out_low_ready),
    .out_low       (out_low),
    .out_high_valid(out_high_valid),
    .out_high_ready(out_high_ready),
    .out_high      (out_high),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    logic lane;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    control  = c;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
`ifdef DXM_DEMUX_ALT_EN
      lane = tog;
`else
      lane = c;
`endif
      if (in_ready) begin
        if (lane) q_high.push_back(d);
        else      q_low.push_back(d);
        tog  = ~tog;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Pops happen at the next rising edge; compare against the scoreboard head on the falling edge.
  always @(negedge clk) begin
    if (out_low_valid && out_low_ready) begin
      if (q_low.size() == 0) chk("low_unexpected", {24'd0, out_low}, 32'hFFFF_FFFF);
      else chk("low_data", {24'd0, out_low}, {24'd0, q_low.pop_front()});
    end
    if (out_high_valid && out_high_ready) begin
      if (q_high.size() == 0) chk("high_unexpected", {24'd0, out_high}, 32'hFFFF_FFFF);
      else chk("high_data", {24'd0, out_high}, {24'd0, q_high.pop_front()});
    end
  end

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b1;
    in_data        = 8'hEE;
    control        = 1'b0;
    out_low_ready  = 1'b0;
    out_high_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_low_valid", {31'd0, out_low_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_low", {24'd0, out_low}, 32'd0);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;

`ifndef DXM_DEMUX_ALT_EN
    // Basic routing
    out_low_ready  = 1'b1;
    out_high_ready = 1'b1;
    send(8'h11, 1'b0);
    chk("route_low_valid", {31'd0, out_low_valid}, 32'd1);
    chk("route_low_data", {24'd0, out_low}, 32'h11);
    send(8'h22, 1'b1);
    chk("route_high_valid", {31'd0, out_high_valid}, 32'd1);
    chk("route_high_data", {24'd0, out_high}, 32'h22);
    step();
    chk("route_busy_idle", {31'd0, busy}, 32'd0);

    // Lane full
    out_low_ready  = 1'b0;
    out_high_ready = 1'b0;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA2;
    control  = 1'b0;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    #1;
    chk("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("full_head_stable", {24'd0, out_low}, 32'hA0);

    // Independence: high lane takes a word while low is full
    out_high_ready = 1'b1;
    send(8'h5C, 1'b1);
    chk("indep_high_valid", {31'd0, out_high_valid}, 32'd1);
    chk("indep_high_data", {24'd0, out_high}, 32'h5C);

    // Full plus pop: input still blocked, nothing overwritten
    in_valid      = 1'b1;
    in_data       = 8'hA2;
    control       = 1'b0;
    out_low_ready = 1'b1;
    #1;
    chk("fullpop_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("fullpop_head", {24'd0, out_low}, 32'hA1);
    chk("fullpop_valid", {31'd0, out_low_valid}, 32'd1);
    chk("fullpop_ready_after", {31'd0, in_ready}, 32'd1);
    send(8'hA2, 1'b0);
    step();
    step();
    chk("drain_low_empty", {31'd0, out_low_valid}, 32'd0);
    chk("drain_low_zero", {24'd0, out_low}, 32'd0);

    // Reset mid-operation
    out_low_ready  = 1'b0;
    out_high_ready = 1'b0;
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h51, 1'b1);
    send(8'h52, 1'b1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_high_head", {24'd0, out_high}, 32'h51);
    reset = 1'b1;
    step();
    reset = 1'b0;
    q_low.delete();
    q_high.delete();
    chk("mr_low_valid", {31'd0, out_low_valid}, 32'd0);
    chk("mr_high_valid", {31'd0, out_high_valid}, 32'd0);
    chk("mr_out_low", {24'd0, out_low}, 32'd0);
    chk("mr_out_high", {24'd0, out_high}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    out_low_ready  = 1'b1;
    out_high_ready = 1'b1;
    send(8'h33, 1'b0);
    chk("post_rst_valid", {31'd0, out_low_valid}, 32'd1);
    chk("post_rst_data", {24'd0, out_low}, 32'h33);
`else
    // Alternating lanes with control tied high; stall the high lane
    control        = 1'b1;
    out_low_ready  = 1'b1;
    out_high_ready = 1'b0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    chk("alt_high_head", {24'd0, out_high}, 32'h02);
    send(8'h05, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h06;
    #1;
    chk("alt_blocked", {31'd0, in_ready}, 32'd0);
    step();
    step();
    #1;
    chk("alt_blocked_hold", {31'd0, in_ready}, 32'd0);
    chk("alt_low_empty", {31'd0, out_low_valid}, 32'd0);
    in_valid       = 1'b0;
    out_high_ready = 1'b1;
    send(8'h06, 1'b1);
`endif

    for (int i = 0; i < 6; i++) step();
    chk("end_low_queue", q_low.size(), 32'd0);
    chk("end_high_queue", q_high.size(), 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dxm_demux_buf.md
Name: dxm_demux_buf

Overview:
- Registered 1-to-2 demultiplexer with per-lane buffering. It is the steering counterpart of the 2:1 selector in the dx macro library.
- Each word accepted on the input is routed to either the low lane or the high lane, then buffered in a 2-entry per-lane FIFO with valid/ready handshake.
- Used in the TRNG datapath to split one entropy/sample stream between two consumers, e.g. the health-test path and the collection path.

Parameters:
- mux_width, 1, data width of the input and of each output lane.
- lane_depth, 2, entries per lane FIFO; legal values 2 and 4 only.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  selected lane can accept this cycle.
- in_data  input  mux_width  input word.
- control  input  1  lane select: 0 routes to low lane, 1 routes to high lane. Sampled in the same cycle as in_valid.
- out_low_valid  output  1  low lane head entry valid.
- out_low_ready  input  1  low-lane consumer accepts head.
- out_low  output  mux_width  low lane head data.
- out_high_valid  output  1  high lane head entry valid.
- out_high_ready  input  1  high-lane consumer accepts head.
- out_high  output  mux_width  high lane head data.
- busy  output  1  either lane non-empty.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset:
  - Both lane counts go to 0, and read/write pointers go to 0.
  - out_low_valid, out_high_valid and busy read 0 from the first cycle after reset is sampled.
  - out_low and out_high read all zeros.
  - An in-flight word is discarded.
  - in_ready is 0 while reset is asserted.
- Accept: a transfer occurs when in_valid && in_ready.
  - in_ready = (selected lane count < lane_depth). It is combinational from control and the lane count.
  - in_ready does not depend on the same-cycle output pop: a full lane blocks input even if it is being popped in that cycle.
- Latency: an accepted word is visible at the lane head (valid=1) on the next cycle when the lane was empty. Otherwise it waits behind older entries.
- Pop: a lane pops when its valid && ready. Count decrements and the read pointer advances (wrap modulo lane_depth).
- Simultaneous push and pop on the same lane: the count is unchanged and both pointers advance. Ordering is strict FIFO per lane.
- Lanes are independent. Backpressure on one lane never blocks a word destined for the other lane.
- Output data when a lane is empty: drive all zeros, never stale data.
- Output stability: while out_x_valid=1 and out_x_ready=0, out_x holds its value.
- Data width: data is passed bit-exact. No transformation, no padding.
- The per-lane count register is clog2(lane_depth)+1 bits wide and never exceeds lane_depth.
- busy = out_low_valid | out_high_valid.
- in_valid with control changing between cycles is legal; each word uses the control value sampled in its own accept cycle.

Optional Feature:
- Macro: DXM_DEMUX_ALT_EN.
- Defined:
  - control is ignored.
  - An internal toggle selects the lane; it resets to 0 (low lane) and inverts after every accepted word.
  - in_ready follows the toggle-selected lane.
  - The toggle only advances on accept, so a blocked word stays on the same lane.
- Undefined: no toggle flop exists; the lane is selected by control exactly as described above.

Test Plan (mux_width=8, lane_depth=2):
- Basic routing: after reset, send 0x11 with control=0 and 0x22 with control=1, both out_*_ready=1.
  - Required: out_low=0x11 valid one cycle after accept; out_high=0x22 valid one cycle after its accept; busy then returns to 0.
- Lane full: hold out_low_ready=0 and send 0xA0, 0xA1, 0xA2 on the low lane.
  - Required: first two accepted, in_ready=0 on the third; out_low stays 0xA0.
  - Then raise ready: order is 0xA0, 0xA1, then 0xA2 accepted.
- Independence: with the low lane full, send 0x5C with control=1.
  - Required: accepted immediately; out_high=0x5C next cycle.
- Full plus pop: low lane full, out_low_ready=1 and in_valid with control=0 in the same cycle.
  - Required: in_ready=0, count goes to 1, no overwrite.
- Reset mid-operation: both lanes holding 2 entries, assert reset for one cycle.
  - Required: all valids 0, outputs 0x00, busy=0; a subsequent 0x33 on the low lane appears after 1 cycle.
- With DXM_DEMUX_ALT_EN: send 0x01, 0x02, 0x03, 0x04 with control tied to 1.
  - Required: low lane receives 0x01, 0x03; high lane receives 0x02, 0x04.
  - Stalling the high lane holds the toggle on high.
